// File: rtl/fetch_types_pkg.sv
// Shared fetch-stage types: sequencer state encoding and a fetch-group record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   fetch_seq_state_t : FSM state of fetch_pc_sequencer (IDLE..DONE, 3 bits)
//   fetch_entry_t     : one fetch-group descriptor (pc + valid) for stage interfaces
package fetch_types_pkg;

  // Widest PC carried in the shared fetch-group record.
  localparam int FETCH_PC_W = 32;

  // Encodings are architecturally visible on state_out, so they are pinned.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_BUBBLE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } fetch_seq_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic                  vld;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: walks fetch groups from boot_pc to END_PC, honours predictor and flush redirects, then drains.
// Latency: fetch_valid is combinational in the current cycle; the next fetch_pc lands one clock after a fire or flush.
// Backpressure: stall_in or !fq_ready holds fetch_pc and suppresses fetch_valid; a flush overrides both.
//
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   start, boot_pc              : launch fetching from boot_pc (only while IDLE)
//   stall_in, fq_ready          : downstream stall, fetch queue can take a group
//   flush_valid, flush_pc       : retirement redirect (highest priority)
//   pred_valid, pred_pc         : predictor redirect for the group firing now
//   fetch_pc, fetch_valid       : current group PC and its fire strobe
//   fetch_stall                 : stall_in, or sequencer in DRAIN/DONE
//   program_done                : registered end-of-program flag
//   state_out                   : FSM state encoding
//   flush_count                 : saturating count of accepted flushes
module fetch_pc_sequencer
  import fetch_types_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ISSUE_WIDTH  = 3,
  parameter int NO_INSTR     = 33,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] boot_pc,
  input  logic            stall_in,
  input  logic            fq_ready,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  output logic            fetch_stall,
  output logic            program_done,
  output logic [2:0]      state_out,
  output logic [15:0]     flush_count
);

  localparam logic [XLEN-1:0] END_PC   = XLEN'(NO_INSTR * 4);
  localparam logic [XLEN-1:0] GROUP_SZ = XLEN'(4 * ISSUE_WIDTH);

  // Counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  fetch_seq_state_t state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             done_q, done_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [15:0]      fc_q, fc_d;
  logic             fire;
  logic             flush_acc;
  logic             past_end;

  // Next-state / next-PC logic. Flush wins over everything except IDLE,
  // where the pipeline has nothing in flight to redirect.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = done_q;
    drain_d   = drain_q;
    fc_d      = fc_q;
    past_end  = (pc_q >= END_PC);  // unsigned, XLEN bits
    flush_acc = flush_valid && (state_q != ST_IDLE);
    fire      = (state_q == ST_RUN) && !stall_in && fq_ready && !flush_valid && !past_end;

    if (flush_acc) begin
      pc_d    = {flush_pc[XLEN-1:2], 2'b00};
      state_d = ST_BUBBLE;
      done_d  = 1'b0;
      drain_d = '0;
      if (fc_q != 16'hFFFF) begin
        fc_d = fc_q + 16'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_d    = boot_pc;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // End-of-program check does not wait for the fetch queue or stall.
          if (past_end) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else if (fire) begin
            pc_d = pred_valid ? {pred_pc[XLEN-1:2], 2'b00} : (pc_q + GROUP_SZ);
          end
        end
        ST_BUBBLE: begin
          state_d = ST_RUN;
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      drain_q <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      drain_q <= drain_d;
      fc_q    <= fc_d;
    end
  end

  // Gate with rst_n so nothing issues in the cycle reset is being applied,
  // even if the registers still show RUN.
  assign fetch_valid  = fire && rst_n;
  assign fetch_pc     = pc_q;
  assign fetch_stall  = stall_in || (state_q == ST_DRAIN) || (state_q == ST_DONE);
  assign program_done = done_q;
  assign state_out    = state_q;
  assign flush_count  = fc_q;

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 3, instructions per fetch group.
REQ-003 SHALL have parameter NO_INSTR, default 33, program length in instructions; END_PC = NO_INSTR*4.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 3, cycles from end-of-program detection to program_done.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port start  input  1  begin fetching from boot_pc (sampled in IDLE only).
REQ-008 SHALL have port boot_pc  input  XLEN  initial fetch PC.
REQ-009 SHALL have port stall_in  input  1  downstream stall.
REQ-010 SHALL have port fq_ready  input  1  fetch unit can accept a group this cycle.
REQ-011 SHALL have port flush_valid  input  1  retirement mispredict redirect.
REQ-012 SHALL have port flush_pc  input  XLEN  redirect target.
REQ-013 SHALL have port pred_valid  input  1  branch predictor redirect for current group.
REQ-014 SHALL have port pred_pc  input  XLEN  predicted target.
REQ-015 SHALL have port fetch_pc  output  XLEN  registered PC of current fetch group.
REQ-016 SHALL have port fetch_valid  output  1  group at fetch_pc issued this cycle (fire).
REQ-017 SHALL have port fetch_stall  output  1  stall_in OR state in {DRAIN, DONE}.
REQ-018 SHALL have port program_done  output  1  registered end-of-program flag.
REQ-019 SHALL have port state_out  output  3  current FSM state encoding.
REQ-020 SHALL have port flush_count  output  16  saturating count of accepted flushes.

Function
REQ-021 FSM states SHALL be IDLE=0, RUN=1, BUBBLE=2, DRAIN=3, DONE=4.
REQ-022 IDLE: fetch_valid=0; start=1 loads fetch_pc<=boot_pc, state->RUN next cycle.
REQ-023 RUN: fetch_valid SHALL be combinational = !stall_in & fq_ready & !flush_valid & (fetch_pc < END_PC).
REQ-024 On fire, next fetch_pc SHALL be pred_pc if pred_valid, else fetch_pc + 4*ISSUE_WIDTH (modulo 2^XLEN).
REQ-025 pred_valid SHALL be ignored when not firing; fetch_pc holds on stall or !fq_ready.
REQ-026 pred_pc and flush_pc SHALL have bits [1:0] forced to zero when loaded.
REQ-027 Flush priority: flush_valid in RUN/BUBBLE/DRAIN/DONE SHALL load fetch_pc<=flush_pc, go to BUBBLE, override pred_valid and stall_in; ignored in IDLE.
REQ-028 BUBBLE: fetch_valid=0 for exactly one cycle, then RUN (unless another flush, which re-enters BUBBLE).
REQ-029 RUN with fetch_pc >= END_PC and no flush SHALL go to DRAIN, loading a drain counter with DRAIN_CYCLES-1.
REQ-030 DRAIN SHALL decrement each cycle; at 0 go to DONE and set program_done=1 the same edge.
REQ-031 Flush in DRAIN/DONE SHALL clear program_done and the drain counter.
REQ-032 flush_count SHALL increment on each accepted flush, saturating at 16'hFFFF.
REQ-033 Comparison with END_PC SHALL be unsigned, XLEN bits.

Reset
REQ-034 rst_n=0 at a clock edge SHALL set state=IDLE, fetch_pc=0, program_done=0, flush_count=0, drain counter=0, regardless of current state or inputs.
REQ-035 During and one cycle after reset, fetch_valid SHALL be 0.

Structure
REQ-036 State enum (fetch_seq_state_t) SHALL live in fetch_types_pkg alongside fetch_entry_t.
REQ-037 Implementation SHALL be a single module; next-PC mux and FSM in one always_comb, registers in one always_ff.

Verification
REQ-038 Reset then start, boot_pc=0, fq_ready=1, no stalls -> fetch_pc 0,12,24,...,132; DRAIN at 132; program_done at +3 cycles.
REQ-039 RUN at fetch_pc=12, pred_valid=1, pred_pc=0x43 on fire -> next fetch_pc=0x40.
REQ-040 flush_valid with pred_valid and stall_in all high, flush_pc=0x20 -> fetch_pc=0x20, one BUBBLE cycle with fetch_valid=0, then fire; flush_count +1.
REQ-041 stall_in=1 for 4 cycles at fetch_pc=24 -> fetch_valid=0, fetch_pc holds 24, resumes at 36.
REQ-042 In DONE, flush_pc=0x10 -> program_done=0 next cycle, BUBBLE, RUN from 0x10.
REQ-043 rst_n=0 mid-DRAIN -> IDLE, all outputs at reset values next cycle; start ignored while rst_n=0.
